phase_sink_sync: RTL and testbench



---
 rtl/phase_sink_sync.sv | 191 +++++++++++++++++++
 tb/tb_phase_sink_sync.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_sink_sync.sv
// Clocked receiver for the three dual-rail phase tokens of the asynchronous phase ring.
// Define PHASE_TIMEOUT_EN to build the per-state watchdog (err_code 0 on expiry).
module phase_sink_sync #(
  parameter int SYNC_STAGES    = 2,
  parameter int SETTLE_CYCLES  = 2,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       PH0,
  input  logic [1:0]       PH1,
  input  logic [1:0]       PH2,
  output logic             ack,
  output logic [2:0]       phase_vec,
  output logic [1:0]       phase_idx,
  output logic             phase_stb,
  output logic [CNT_W-1:0] rot_cnt,
  output logic             err_stb,
  output logic [1:0]       err_code
);

  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("SYNC_STAGES must be at least 2");
  end
  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("SETTLE_CYCLES must be at least 1");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

  typedef enum logic {WAIT_DATA, WAIT_NULL} state_e;

  localparam int SC_W = $clog2(SETTLE_CYCLES + 1);

  logic [SYNC_STAGES-1:0][5:0] sync_q, sync_d;
  logic [5:0]                  samp_q, samp_d;
  logic [SC_W-1:0]             settle_q, settle_d;
  state_e                      state_q, state_d;
  logic                        ack_q, ack_d;
  logic [2:0]                  phase_vec_q, phase_vec_d;
  logic [1:0]                  phase_idx_q, phase_idx_d;
  logic [1:0]                  exp_idx_q, exp_idx_d;
  logic                        phase_stb_q, phase_stb_d;
  logic [CNT_W-1:0]            rot_cnt_q, rot_cnt_d;
  logic                        err_stb_q, err_stb_d;
  logic [1:0]                  err_code_q, err_code_d;

  logic [2:0] in_nn, nn, illegal, tru;
  logic       settled, is_code, is_space, onehot;
  logic [1:0] idx;

`ifdef PHASE_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_q, wd_d;
`endif

  // Per-phase rail decode: {true, false}; 00 null, 11 illegal.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      in_nn[i]   = |samp_d[2*i +: 2];
      nn[i]      = |samp_q[2*i +: 2];
      illegal[i] = &samp_q[2*i +: 2];
      tru[i]     = samp_q[2*i + 1];
    end
    is_code  = &nn;
    is_space = ~|nn;
    settled  = (settle_q >= SC_W'(SETTLE_CYCLES));
    onehot   = (tru == 3'b001) || (tru == 3'b010) || (tru == 3'b100);
    case (tru)
      3'b010:  idx = 2'd1;
      3'b100:  idx = 2'd2;
      default: idx = 2'd0;
    endcase
  end

  // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
  always_comb begin
    sync_d[0] = {PH2, PH1, PH0};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
    samp_d = sync_q[SYNC_STAGES-1];

    // A transitional (mixed) sample or any change restarts the settle count.
    if (in_nn != 3'b000 && in_nn != 3'b111) settle_d = '0;
    else if (samp_d != samp_q)              settle_d = SC_W'(1);
    else if (!settled)                      settle_d = settle_q + SC_W'(1);
    else                                    settle_d = settle_q;

    state_d     = state_q;
    ack_d       = ack_q;
    phase_vec_d = phase_vec_q;
    phase_idx_d = phase_idx_q;
    exp_idx_d   = exp_idx_q;
    phase_stb_d = 1'b0;
    rot_cnt_d   = rot_cnt_q;
    err_stb_d   = 1'b0;
    err_code_d  = err_code_q;

    case (state_q)
      WAIT_DATA: begin
        if (settled && is_code) begin
          state_d     = WAIT_NULL;
          ack_d       = 1'b1;
          phase_vec_d = tru;
          phase_stb_d = 1'b1;
          if (|illegal) begin
            err_stb_d  = 1'b1;
            err_code_d = 2'd1;
          end else if (!onehot) begin
            err_stb_d  = 1'b1;
            err_code_d = 2'd2;
          end else if (idx != exp_idx_q) begin
            err_stb_d  = 1'b1;
            err_code_d = 2'd3;
          end else begin
            phase_idx_d = idx;
            exp_idx_d   = (idx == 2'd2) ? 2'd0 : idx + 2'd1;
            if (idx == 2'd0) rot_cnt_d = rot_cnt_q + CNT_W'(1);
          end
        end
      end
      WAIT_NULL: begin
        if (settled && is_space) begin
          state_d = WAIT_DATA;
          ack_d   = 1'b0;
        end
      end
      default: state_d = WAIT_DATA;
    endcase

`ifdef PHASE_TIMEOUT_EN
    // Any state change counts as progress; otherwise expire and reload.
    if (state_d != state_q) begin
      wd_d = '0;
    end else if (wd_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
      wd_d       = '0;
      err_stb_d  = 1'b1;
      err_code_d = 2'd0;
    end else begin
      wd_d = wd_q + WD_W'(1);
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so all flops update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q      <= '0;
      samp_q      <= '0;
      settle_q    <= '0;
      state_q     <= WAIT_DATA;
      ack_q       <= 1'b0;
      phase_vec_q <= 3'b000;
      phase_idx_q <= 2'd0;
      exp_idx_q   <= 2'd0;
      phase_stb_q <= 1'b0;
      rot_cnt_q   <= '0;
      err_stb_q   <= 1'b0;
      err_code_q  <= 2'd0;
`ifdef PHASE_TIMEOUT_EN
      wd_q        <= '0;
`endif
    end else begin
      sync_q      <= sync_d;
      samp_q      <= samp_d;
      settle_q    <= settle_d;
      state_q     <= state_d;
      ack_q       <= ack_d;
      phase_vec_q <= phase_vec_d;
      phase_idx_q <= phase_idx_d;
      exp_idx_q   <= exp_idx_d;
      phase_stb_q <= phase_stb_d;
      rot_cnt_q   <= rot_cnt_d;
      err_stb_q   <= err_stb_d;
      err_code_q  <= err_code_d;
`ifdef PHASE_TIMEOUT_EN
      wd_q        <= wd_d;
`endif
    end
  end

  assign ack       = ack_q;
  assign phase_vec = phase_vec_q;
  assign phase_idx = phase_idx_q;
  assign phase_stb = phase_stb_q;
  assign rot_cnt   = rot_cnt_q;
  assign err_stb   = err_stb_q;
  assign err_code  = err_code_q;

endmodule

// File: tb/tb_phase_sink_sync.sv
// Self-checking bench for phase_sink_sync: directed handshakes, then random tokens
// checked against a token-level model of the phase ring rules.
module tb_phase_sink_sync;

  localparam int SYNC_STAGES   = 2;
  localparam int SETTLE_CYCLES = 2;
  localparam int CNT_W         = 16;
  localparam int LAT           = SYNC_STAGES + SETTLE_CYCLES + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [1:0]       ph0, ph1, ph2;
  logic             ack;
  logic [2:0]       phase_vec;
  logic [1:0]       phase_idx;
  logic             phase_stb;
  logic [CNT_W-1:0] rot_cnt;
  logic             err_stb;
  logic [1:0]       err_code;

  int checks = 0;
  int errors = 0;

  // Token-level model state.
  int m_exp, m_idx, m_rot, m_code;

  phase_sink_sync #(
    .SYNC_STAGES   (SYNC_STAGES),
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .CNT_W         (CNT_W),
    .TIMEOUT_CYCLES(1024)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .PH0      (ph0),
    .PH1      (ph1),
    .PH2      (ph2),
    .ack      (ack),
    .phase_vec(phase_vec),
    .phase_idx(phase_idx),
    .phase_stb(phase_stb),
    .rot_cnt  (rot_cnt),
    .err_stb  (err_stb),
    .err_code (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_exp  = 0;
    m_idx  = 0;
    m_rot  = 0;
    m_code = 0;
  endtask

  // Present one codeword (PH2 optionally delayed by skew clocks), complete the handshake.
  task automatic run_token(input logic [1:0] r0, input logic [1:0] r1, input logic [1:0] r2,
                           input int skew);
    int ones, idx, e_code, lat, early;
    logic [2:0] e_vec;
    ones = int'(r0 == 2'b10) + int'(r1 == 2'b10) + int'(r2 == 2'b10);
    idx  = (r1 == 2'b10) ? 1 : (r2 == 2'b10) ? 2 : 0;
    if (r0 == 2'b11 || r1 == 2'b11 || r2 == 2'b11) e_code = 1;
    else if (ones != 1)                            e_code = 2;
    else if (idx != m_exp)                         e_code = 3;
    else                                           e_code = 0;
    e_vec = {r2[1], r1[1], r0[1]};

    early = 0;
    ph0 = r0;
    ph1 = r1;
    if (skew > 0) begin
      ph2 = 2'b00;
      for (int k = 0; k < skew; k++) begin
        @(negedge clk);
        if (phase_stb === 1'b1) early++;
      end
      check("stb_during_skew", early, 0);
    end
    ph2 = r2;

    lat = -1;
    for (int c = 1; c <= 4 * LAT; c++) begin
      @(negedge clk);
      if (phase_stb === 1'b1) begin
        lat = c;
        break;
      end
    end
    check("stb_latency", lat, LAT);
    check("ack_rise", ack, 1);
    check("phase_vec", phase_vec, e_vec);
    check("err_stb", err_stb, (e_code != 0));

    if (e_code != 0) begin
      m_code = e_code;
    end else begin
      m_idx = idx;
      m_exp = (idx + 1) % 3;
      if (idx == 0) m_rot = (m_rot + 1) % (1 << CNT_W);
    end
    check("phase_idx", phase_idx, m_idx);
    check("err_code", err_code, m_code);
    check("rot_cnt", rot_cnt, m_rot);

    @(negedge clk);
    check("stb_width", phase_stb, 0);
    check("err_width", err_stb, 0);

    ph0 = 2'b00;
    ph1 = 2'b00;
    ph2 = 2'b00;
    lat = -1;
    for (int c = 1; c <= 4 * LAT; c++) begin
      @(negedge clk);
      if (ack === 1'b0) begin
        lat = c;
        break;
      end
    end
    check("ack_fall_latency", lat, LAT);
  endtask

  initial begin
    logic [1:0] r [3];
    int cat, z, pulses, last_code, lat;

    rst = 1'b1;
    ph0 = 2'b00;
    ph1 = 2'b00;
    ph2 = 2'b00;
    model_reset();
    repeat (3) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_phase_vec", phase_vec, 0);
    check("rst_phase_idx", phase_idx, 0);
    check("rst_phase_stb", phase_stb, 0);
    check("rst_err_stb", err_stb, 0);
    check("rst_err_code", err_code, 0);
    check("rst_rot_cnt", rot_cnt, 0);
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // First token, full rotation, then error cases and a skewed arrival.
    run_token(2'b10, 2'b01, 2'b01, 0);
    run_token(2'b01, 2'b10, 2'b01, 0);
    run_token(2'b01, 2'b01, 2'b10, 0);
    run_token(2'b10, 2'b01, 2'b01, 0);
    run_token(2'b11, 2'b01, 2'b01, 0);
    run_token(2'b01, 2'b01, 2'b10, 0);
    run_token(2'b01, 2'b10, 2'b01, 2);
    run_token(2'b01, 2'b01, 2'b10, 3);

    for (int t = 0; t < 40; t++) begin
      cat = $urandom_range(0, 9);
      for (int k = 0; k < 3; k++) r[k] = 2'b01;
      if (cat <= 5) begin
        r[m_exp] = 2'b10;
      end else if (cat == 6) begin
        r[(m_exp + 1 + $urandom_range(0, 1)) % 3] = 2'b10;
      end else if (cat == 8) begin
        z = $urandom_range(0, 2);
        for (int k = 0; k < 3; k++) if (k != z) r[k] = 2'b10;
      end else if (cat == 9) begin
        for (int k = 0; k < 3; k++) r[k] = ($urandom_range(0, 1) != 0) ? 2'b10 : 2'b01;
        r[$urandom_range(0, 2)] = 2'b11;
      end
      run_token(r[0], r[1], r[2], $urandom_range(0, 3));
    end

    // Idle with null rails beyond the watchdog limit.
    pulses    = 0;
    last_code = -1;
    for (int c = 0; c < 1100; c++) begin
      @(negedge clk);
      if (err_stb === 1'b1) begin
        pulses++;
        last_code = int'(err_code);
      end
    end
`ifdef PHASE_TIMEOUT_EN
    check("wd_pulses", pulses, 1);
    check("wd_code", last_code, 0);
    m_code = 0;
`else
    check("idle_no_err", pulses, 0);
`endif
    check("idle_ack", ack, 0);

    // Reset in the middle of a handshake.
    ph0 = 2'b10;
    ph1 = 2'b01;
    ph2 = 2'b01;
    lat = -1;
    for (int c = 1; c <= 4 * LAT; c++) begin
      @(negedge clk);
      if (ack === 1'b1) begin
        lat = c;
        break;
      end
    end
    check("ack_up_before_reset", ack, 1);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_ack", ack, 0);
    check("mid_rst_phase_stb", phase_stb, 0);
    check("mid_rst_phase_idx", phase_idx, 0);
    check("mid_rst_phase_vec", phase_vec, 0);
    check("mid_rst_rot_cnt", rot_cnt, 0);
    check("mid_rst_err_code", err_code, 0);
    ph0 = 2'b00;
    ph1 = 2'b00;
    ph2 = 2'b00;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    run_token(2'b10, 2'b01, 2'b01, 0);
    run_token(2'b01, 2'b10, 2'b01, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

endmodule
